// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

  localparam int INSTR_W           = 16;
  localparam int DEFAULT_MAX_WORDS = 256;

  // Ten states need four bits; the final code is outside the used range.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_HI  = 4'd1,
    S_LEN_LO  = 4'd2,
    S_CHK_LEN = 4'd3,
    S_DATA_HI = 4'd4,
    S_DATA_LO = 4'd5,
    S_WRITE   = 4'd6,
    S_CSUM    = 4'd7,
    S_DONE    = 4'd8,
    S_ERR     = 4'd15
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the loader, grouped as one bundle.
interface imem_loader_if #(
  parameter int ADDR_W = 16
);
  import imem_loader_pkg::*;

  logic                in_valid;
  logic [7:0]          in_data;
  logic                in_ready;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [INSTR_W-1:0]  wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/imem_loader_byte_pair_assembler.sv
// Pairs high/low bytes into instruction words and keeps the running XOR
// of every payload byte seen since the last clear.
module byte_pair_assembler
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               hi_en,
  input  logic               lo_en,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] word,
  output logic [7:0]         csum
);

  logic [7:0] hi_byte;

  // NOTE: clocked blocks use <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_byte <= '0;
      word    <= '0;
      csum    <= '0;
    end else if (clear) begin
      hi_byte <= '0;
      word    <= '0;
      csum    <= '0;
    end else if (hi_en) begin
      hi_byte <= data;
      csum    <= csum ^ data;
    end else if (lo_en) begin
      word    <= {hi_byte, data};
      csum    <= csum ^ data;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header, payload words written to imem from address 0,
// trailing XOR checksum; the CPU is held until a load completes cleanly.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int MAX_WORDS = DEFAULT_MAX_WORDS,
  parameter int ADDR_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_hold,
  imem_loader_if.slave  bus
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  state_t              state, next_state;
  logic [15:0]         count;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic                in_ready_q, wr_en_q, busy_q, done_q, error_q;
  logic                xfer, start_load, hi_en, lo_en;
  logic [INSTR_W-1:0]  word;
  logic [7:0]          csum;

  assign xfer       = bus.in_valid & in_ready_q;
  assign start_load = start & (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign hi_en      = (state == S_DATA_HI) & xfer;
  assign lo_en      = (state == S_DATA_LO) & xfer;

  byte_pair_assembler u_asm (
    .clk   (clk),
    .rst   (rst),
    .clear (start_load),
    .hi_en (hi_en),
    .lo_en (lo_en),
    .data  (bus.in_data),
    .word  (word),
    .csum  (csum)
  );

  // NOTE: default assigned first so every path sets next_state and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) next_state = S_LEN_HI;
      S_LEN_HI:  if (xfer) next_state = S_LEN_LO;
      S_LEN_LO:  if (xfer) next_state = S_CHK_LEN;
      S_CHK_LEN: begin
        if (count > MAX_CNT)    next_state = S_ERR;
        else if (count == '0)   next_state = S_CSUM;
        else                    next_state = S_DATA_HI;
      end
      S_DATA_HI: if (xfer) next_state = S_DATA_LO;
      S_DATA_LO: if (xfer) next_state = S_WRITE;
      S_WRITE:   next_state = (count == 16'd1) ? S_CSUM : S_DATA_HI;
      S_CSUM:    if (xfer) next_state = (bus.in_data == csum) ? S_DONE : S_ERR;
      default:   next_state = S_IDLE;
    endcase
  end

  // Status flags are registered from next_state so they align with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      count      <= '0;
      wr_addr_q  <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state      <= next_state;
      in_ready_q <= next_state inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM};
      wr_en_q    <= (next_state == S_WRITE);
      busy_q     <= !(next_state inside {S_IDLE, S_DONE, S_ERR});
      done_q     <= (next_state == S_DONE);
      error_q    <= (next_state == S_ERR);

      if (start_load) begin
        wr_addr_q <= '0;
        count     <= '0;
      end
      if (state == S_LEN_HI && xfer) count[15:8] <= bus.in_data;
      if (state == S_LEN_LO && xfer) count[7:0]  <= bus.in_data;
      if (state == S_WRITE) begin
        count <= count - 16'd1;
        // The final word leaves the address on MAX_WORDS-1 at most.
        if (count != 16'd1) wr_addr_q <= wr_addr_q + ADDR_W'(1);
      end
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = word;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  // A start accepted from DONE re-freezes the CPU in that same cycle.
  assign cpu_hold     = ~done_q | start;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized directed bench for imem_loader with a queue-based write model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int MAXW = 256;
  localparam int AW   = 16;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, error, cpu_hold;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  bit          jitter = 1'b0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          n_writes = 0;
  logic [15:0] last_addr = '0;
  logic [15:0] last_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Every write must match the next entry the model expects.
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      n_writes++;
      last_addr = bus.wr_addr;
      last_data = bus.wr_data;
      check("wr_addr_in_range", 32'(bus.wr_addr <= 16'(MAXW - 1)), 1);
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", bus.wr_addr, mon_e.addr);
        check("wr_data", bus.wr_data, mon_e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xor_of(input logic [15:0] w[$]);
    logic [7:0] r = '0;
    foreach (w[i]) r = r ^ w[i][15:8] ^ w[i][7:0];
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    if (jitter) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("in_ready_timeout", 32'(waited), 0);
    else @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    #1 check("cpu_hold_with_start", 32'(cpu_hold), 1);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input logic [15:0] words[$], input logic [7:0] flip, input int start_at);
    logic [15:0] hdr;
    hdr = 16'(words.size());
    pulse_start();
    foreach (words[i]) exp_q.push_back('{addr: 16'(i), data: words[i]});
    send_byte(hdr[15:8]);
    send_byte(hdr[7:0]);
    foreach (words[i]) begin
      if (i == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_ignored_start", 32'(busy), 1);
      end
      send_byte(words[i][15:8]);
      send_byte(words[i][7:0]);
    end
    send_byte(xor_of(words) ^ flip);
  endtask

  task automatic check_outcome(input string tag, input bit pass);
    check({tag, "_done"},     32'(done),     32'(pass));
    check({tag, "_error"},    32'(error),    32'(!pass));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!pass));
    check({tag, "_busy"},     32'(busy),     0);
    check({tag, "_writes_pending"}, 32'(exp_q.size()), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
    check({tag, "_wr_en"},    32'(bus.wr_en),    0);
    check({tag, "_busy"},     32'(busy),         0);
    check({tag, "_done"},     32'(done),         0);
    check({tag, "_error"},    32'(error),        0);
    check({tag, "_wr_addr"},  32'(bus.wr_addr),  0);
    check({tag, "_wr_data"},  32'(bus.wr_data),  0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold),     1);
  endtask

  initial begin
    logic [15:0] w[$];
    int          base;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);

    // Two-word load with correct checksum, then with a corrupted one.
    w = '{16'h1234, 16'hABCD};
    run_load(w, 8'h00, -1);
    check_outcome("two_word_ok", 1'b1);
    check("two_word_last_addr", 32'(last_addr), 1);
    run_load(w, 8'h01, -1);
    check_outcome("bad_csum", 1'b0);

    // Retry with random words and a stalling source.
    jitter = 1'b1;
    w.delete();
    repeat (3) w.push_back(16'($urandom));
    run_load(w, 8'h00, -1);
    check_outcome("retry_ok", 1'b1);

    // Oversized header: rejected before any payload.
    base = n_writes;
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h01);
    @(negedge clk);
    check_outcome("oversize", 1'b0);
    repeat (4) @(negedge clk);
    check("oversize_in_ready", 32'(bus.in_ready), 0);
    check("oversize_no_writes", 32'(n_writes - base), 0);

    // Empty payload.
    base = n_writes;
    w.delete();
    run_load(w, 8'h00, -1);
    check_outcome("empty", 1'b1);
    check("empty_no_writes", 32'(n_writes - base), 0);

    // start and rst together: rst wins.
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check_reset("start_rst");
    @(negedge clk);
    check("start_rst_busy", 32'(busy), 0);

    // Reset after the first word of a three-word load.
    base = n_writes;
    w.delete();
    repeat (3) w.push_back(16'($urandom));
    pulse_start();
    exp_q.push_back('{addr: 16'd0, data: w[0]});
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(w[0][15:8]);
    send_byte(w[0][7:0]);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("mid_rst");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_rst_writes", 32'(n_writes - base), 1);
    check("mid_rst_cpu_hold", 32'(cpu_hold), 1);
    check("mid_rst_busy", 32'(busy), 0);

    // Full-capacity load, data equal to address, with an ignored start mid-way.
    base = n_writes;
    w.delete();
    for (int i = 0; i < MAXW; i++) w.push_back(16'(i));
    run_load(w, 8'h00, 100);
    check_outcome("full", 1'b1);
    check("full_write_count", 32'(n_writes - base), MAXW);
    check("full_last_addr", 32'(last_addr), 32'h00FF);
    check("full_last_data", 32'(last_data), 32'h00FF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
